// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// A packed BCD value is latched on start, checked for illegal digits, then
// shifted right one bit per clock with a subtract-3 correction on every digit.
// The binary result saturates to all ones when it exceeds OUT_W bits.
//
// Handshake: start is sampled only while idle (busy=0); busy stays high from
// the accepting edge through CHECK, CONV and DONE; done is a one-cycle pulse
// marking the cycle in which bin_out/ovf/err first show the new result.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  ovf,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BW + 1);
    localparam logic [CW-1:0] LAST = CW'(BW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [BW-1:0]       s_reg;
    logic [BW-1:0]       b_reg;
    logic [BW-1:0]       s_step;
    logic [BW-1:0]       b_step;
    logic [2*BW-1:0]     sb_shift;
    logic [BW+OUT_W-1:0] b_ext;
    logic [CW-1:0]       cnt;
    logic                err_pend;
    logic                bad_digit;
    logic                ovf_c;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Flag any latched digit that is not a legal BCD value (above 9).
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (s_reg[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift {S,B} right, then pull 3 out of
    // every BCD digit whose top bit became set (a digit >= 8 after shifting).
    always_comb begin
        sb_shift = {s_reg, b_reg} >> 1;
        s_step   = sb_shift[2*BW-1:BW];
        b_step   = sb_shift[BW-1:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (s_step[4*i+3]) begin
                s_step[4*i +: 4] = s_step[4*i +: 4] - 4'd3;
            end
        end
    end

    // Saturation detect: any set bit of B above the output width.
    always_comb begin
        b_ext = {{OUT_W{1'b0}}, b_reg};
        ovf_c = |(b_ext >> OUT_W);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CHECK;
            CHECK:   state_nx = bad_digit ? DONE : CONV;
            CONV:    if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Working registers: latch on accept, record validity, iterate in CONV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg    <= '0;
            b_reg    <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s_reg    <= bcd_in;
                        b_reg    <= '0;
                        cnt      <= '0;
                        err_pend <= 1'b0;
                    end
                end
                CHECK: err_pend <= bad_digit;
                CONV: begin
                    s_reg <= s_step;
                    b_reg <= b_step;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers: written once per conversion, held through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            bin_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                err <= err_pend;
                ovf <= ~err_pend & ovf_c;
                if (err_pend) begin
                    bin_out <= '0;
                end else if (ovf_c) begin
                    bin_out <= '1;
                end else begin
                    bin_out <= b_ext[OUT_W-1:0];
                end
            end
        end
    end

endmodule
